// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSN_NOP    = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with single-cycle flush; Depth must be a power of two.
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  fetch_entry_t       wdata_i,
  input  logic               pop_i,
  input  logic               flush_i,
  output fetch_entry_t       rdata_o,
  output logic [CntW-1:0]    count_o,
  output logic               empty_o,
  output logic               full_o
);

  localparam logic [CntW-1:0] DepthC = CntW'(Depth);

  fetch_entry_t           mem_q [Depth];
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DepthC);

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: PC, boot/run/halt FSM, redirect handling and instruction buffer.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module inst_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] MEM_addr,
  output logic        rMEM_en,
  input  logic [31:0] MEM_dout,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        halted,
  output logic        fetch_fault
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t    state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  fetch_entry_t    push_entry, head_entry;
  logic [CntW-1:0] unused_fifo_count;
  logic            fifo_empty, fifo_full, pop;

  assign rMEM_en    = (state_q == S_RUN) && !fifo_full && !redirect_valid;
  assign pop        = inst_valid && inst_ready;
  assign push_entry = '{pc: pc_q, insn: MEM_dout};

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q, fault_d;
  logic redirect_misaligned;
  assign redirect_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign fetch_fault         = fault_q;
`else
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign fetch_fault         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    fault_d = fault_q;
`endif
    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      state_d = S_RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_misaligned) begin
        state_d = S_HALT;
        fault_d = 1'b1;
      end
`endif
    end else begin
      case (state_q)
        S_BOOT: state_d = S_RUN;
        S_RUN: begin
          if (rMEM_en) begin
            pc_d = pc_q + 32'd4;
            // EBREAK itself is still buffered so decode can see it
            if (MEM_dout == INSN_EBREAK) state_d = S_HALT;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q <= fault_d;
`endif
    end
  end

  fetch_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (rMEM_en),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .rdata_o (head_entry),
    .count_o (unused_fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign MEM_addr   = pc_q;
  assign inst_valid = !fifo_empty;
  assign inst       = inst_valid ? head_entry.insn : 32'h0;
  assign inst_pc    = inst_valid ? head_entry.pc : 32'h0;
  assign halted     = (state_q == S_HALT);

endmodule
